// File: rtl/ram_dp_sync_arb.sv
// True dual-port synchronous RAM with byte enables, req/ready handshakes,
// round-robin arbitration of same-address conflicts and an optional post-reset clear.
module ram_dp_sync_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [DATA_WIDTH/8-1:0] p0_be,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  output logic                    p0_ready,
  output logic                    p0_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [DATA_WIDTH/8-1:0] p1_be,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  output logic                    p1_ready,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    init_done,
  output logic                    collision,
  output logic                    dbg_state
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  // Handshake: a request on a port is accepted at a rising edge where req & ready are both 1;
  // a port that is not accepted must hold req/we/be/addr/wdata until it is.
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_ptr;
  logic                  r_init_done;
  logic                  r_collision;
  logic                  r_p0_rvalid;
  logic                  r_p1_rvalid;
  logic [DATA_WIDTH-1:0] r_p0_rdata;
  logic [DATA_WIDTH-1:0] r_p1_rdata;

  logic w_run;
  logic w_conflict;
  logic w_p0_ready;
  logic w_p1_ready;
  logic w_p0_acc;
  logic w_p1_acc;

  assign w_run      = (r_state == S_RUN);
  // Two reads of the same word never conflict; any write to a shared word does.
  assign w_conflict = w_run && p0_req && p1_req && (p0_addr == p1_addr) && (p0_we || p1_we);
  assign w_p0_ready = w_run && (!w_conflict || !r_ptr);
  assign w_p1_ready = w_run && (!w_conflict || r_ptr);
  assign w_p0_acc   = p0_req && w_p0_ready;
  assign w_p1_acc   = p1_req && w_p1_ready;

  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      if (INIT_CLEAR) mem[r_cnt] <= '0;
    end else begin
      if (w_p0_acc && p0_we) begin
        for (int i = 0; i < NB; i++)
          if (p0_be[i]) mem[p0_addr][8*i +: 8] <= p0_wdata[8*i +: 8];
      end
      if (w_p1_acc && p1_we) begin
        for (int i = 0; i < NB; i++)
          if (p1_be[i]) mem[p1_addr][8*i +: 8] <= p1_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_ptr       <= 1'b0;
      r_init_done <= 1'b0;
      r_collision <= 1'b0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_collision <= w_conflict;
      if (w_conflict) r_ptr <= ~r_ptr;
      r_p0_rvalid <= w_p0_acc && !p0_we;
      r_p1_rvalid <= w_p1_acc && !p1_we;
      if (w_p0_acc && !p0_we) r_p0_rdata <= mem[p0_addr];
      if (w_p1_acc && !p1_we) r_p1_rdata <= mem[p1_addr];
      if (r_state == S_INIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (!INIT_CLEAR || (r_cnt == LAST_ADDR)) begin
          r_state     <= S_RUN;
          r_init_done <= 1'b1;
        end
      end
    end
  end

  assign p0_ready  = w_p0_ready;
  assign p1_ready  = w_p1_ready;
  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign init_done = r_init_done;
  assign collision = r_collision;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_dp_sync_arb.sv
// Bench for ram_dp_sync_arb (16 words x 16 bits): directed scenarios plus
// randomized traffic compared every cycle against a word-array reference model.
module tb_ram_dp_sync_arb;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [1:0]    p0_be = '0, p1_be = '0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ready, p0_rvalid, p1_ready, p1_rvalid, init_done, collision, dbg_state;
  logic [DW-1:0] p0_rdata, p1_rdata;

  ram_dp_sync_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .init_done(init_done), .collision(collision), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_ptr, m_done, m_col, m_rv0, m_rv1, m_acc0, m_acc1;
  int            m_left;
  logic [DW-1:0] m_last0, m_last1;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_conflict();
    return m_done && p0_req && p1_req && (p0_addr == p1_addr) && (p0_we || p1_we);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [1:0] be);
    logic [DW-1:0] r;
    r = old;
    if (be[0]) r[7:0]  = wd[7:0];
    if (be[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  // compare every output against the model (called mid-cycle with inputs stable)
  task automatic check_cycle();
    bit conf;
    conf = model_conflict();
    chk("p0_ready", p0_ready, m_done && (!conf || !m_ptr));
    chk("p1_ready", p1_ready, m_done && (!conf || m_ptr));
    chk("init_done", init_done, m_done);
    chk("collision", collision, m_col);
    chk("p0_rvalid", p0_rvalid, m_rv0);
    chk("p1_rvalid", p1_rvalid, m_rv1);
    if (m_rv0 && exp_q0.size() > 0) m_last0 = exp_q0.pop_front();
    if (m_rv1 && exp_q1.size() > 0) m_last1 = exp_q1.pop_front();
    chk("p0_rdata", p0_rdata, m_last0);
    chk("p1_rdata", p1_rdata, m_last1);
  endtask

  // advance the model across the coming rising edge
  task automatic model_edge();
    bit conf;
    conf   = model_conflict();
    m_acc0 = p0_req && m_done && (!conf || !m_ptr);
    m_acc1 = p1_req && m_done && (!conf || m_ptr);
    if (m_acc0 && !p0_we) exp_q0.push_back(m_mem[p0_addr]);
    if (m_acc1 && !p1_we) exp_q1.push_back(m_mem[p1_addr]);
    if (m_acc0 && p0_we) m_mem[p0_addr] = merge(m_mem[p0_addr], p0_wdata, p0_be);
    if (m_acc1 && p1_we) m_mem[p1_addr] = merge(m_mem[p1_addr], p1_wdata, p1_be);
    m_rv0 = m_acc0 && !p0_we;
    m_rv1 = m_acc1 && !p1_we;
    m_col = conf;
    if (conf) m_ptr = !m_ptr;
    if (!m_done) begin
      m_mem[DEPTH - m_left] = '0;
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end
  endtask

  // one clock cycle; called at posedge+1, returns at next posedge+1
  task automatic step();
    @(negedge clk);
    check_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  task automatic drive0(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
  endtask

  task automatic drive1(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
  endtask

  task automatic model_reset();
    m_ptr = 1'b0; m_done = 1'b0; m_col = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
    m_left = DEPTH; m_last0 = '0; m_last1 = '0;
    exp_q0.delete(); exp_q1.delete();
  endtask

  // assert reset at posedge+1, check outputs drop at once, release at a later posedge+1
  task automatic do_reset(input string tag);
    idle();
    rst = 1'b1;
    model_reset();
    #1;
    chk({tag, "_rst_p0_ready"}, p0_ready, 0);
    chk({tag, "_rst_p1_ready"}, p1_ready, 0);
    chk({tag, "_rst_p0_rvalid"}, p0_rvalid, 0);
    chk({tag, "_rst_p1_rvalid"}, p1_rvalid, 0);
    chk({tag, "_rst_p0_rdata"}, p0_rdata, 0);
    chk({tag, "_rst_p1_rdata"}, p1_rdata, 0);
    chk({tag, "_rst_init_done"}, init_done, 0);
    chk({tag, "_rst_collision"}, collision, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  bit h0, h1;
  int ready_low;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset("t1");

    // 1: clear sequence, then readback of every word
    ready_low = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!p0_ready && !p1_ready) ready_low++;
      if (i == DEPTH - 1) chk("t1_init_done_before_last", init_done, 0);
      step();
    end
    chk("t1_ready_low_cycles", ready_low, 16);
    chk("t1_init_done", init_done, 1);
    for (int i = 0; i < DEPTH; i++) begin
      drive0(1'b0, AW'(i), '0, 2'b00);
      drive1(1'b0, AW'(DEPTH - 1 - i), '0, 2'b00);
      step();
    end
    idle();
    chk("t1_rdata_zero", p0_rdata, 16'h0000);
    step();

    // 2: write then read from the other port
    drive0(1'b1, 4'd3, 16'hBEEF, 2'b11);
    step();
    idle();
    drive1(1'b0, 4'd3, '0, 2'b00);
    step();
    idle();
    chk("t2_p1_rvalid", p1_rvalid, 1);
    chk("t2_p1_rdata", p1_rdata, 16'hBEEF);
    chk("t2_collision", collision, 0);
    step();

    // 3: partial byte write
    drive0(1'b1, 4'd3, 16'h1234, 2'b01);
    step();
    drive0(1'b0, 4'd3, '0, 2'b00);
    step();
    idle();
    chk("t3_p0_rdata", p0_rdata, 16'hBE34);
    step();

    // 4: write/write conflict, loser holds, then the pointer favours port 1
    drive0(1'b1, 4'd5, 16'hA5A5, 2'b11);
    drive1(1'b1, 4'd5, 16'h5A5A, 2'b11);
    #1;
    chk("t4_p0_ready_win", p0_ready, 1);
    chk("t4_p1_ready_lose", p1_ready, 0);
    step();
    p0_req = 1'b0;
    #1;
    chk("t4_collision", collision, 1);
    chk("t4_p1_ready_retry", p1_ready, 1);
    step();
    idle();
    drive1(1'b0, 4'd5, '0, 2'b00);
    step();
    idle();
    chk("t4_read5", p1_rdata, 16'h5A5A);
    drive0(1'b1, 4'd5, 16'h1111, 2'b11);
    drive1(1'b1, 4'd5, 16'h2222, 2'b11);
    #1;
    chk("t4_rr_p1_ready", p1_ready, 1);
    chk("t4_rr_p0_ready", p0_ready, 0);
    step();
    p1_req = 1'b0;
    step();
    idle();
    step();

    // 5: same-address double read is not a conflict
    drive0(1'b0, 4'd3, '0, 2'b00);
    drive1(1'b0, 4'd3, '0, 2'b00);
    #1;
    chk("t5_p0_ready", p0_ready, 1);
    chk("t5_p1_ready", p1_ready, 1);
    step();
    idle();
    chk("t5_p0_rdata", p0_rdata, 16'hBE34);
    chk("t5_p1_rdata", p1_rdata, 16'hBE34);
    chk("t5_collision", collision, 0);
    step();

    // randomized traffic on a small address window to provoke conflicts
    h0 = 1'b0;
    h1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!h0) begin
        p0_req = ($urandom_range(0, 3) != 0);
        p0_we = $urandom_range(0, 1); p0_addr = AW'($urandom_range(0, 3));
        p0_wdata = DW'($urandom); p0_be = 2'($urandom_range(0, 3));
      end
      if (!h1) begin
        p1_req = ($urandom_range(0, 3) != 0);
        p1_we = $urandom_range(0, 1); p1_addr = AW'($urandom_range(0, 3));
        p1_wdata = DW'($urandom); p1_be = 2'($urandom_range(0, 3));
      end
      step();
      h0 = p0_req && !m_acc0;
      h1 = p1_req && !m_acc1;
    end
    idle();
    step();

    // reset during RUN with a read in flight
    drive0(1'b0, 4'd3, '0, 2'b00);
    step();
    idle();
    chk("t6_rvalid_inflight", p0_rvalid, 1);
    do_reset("run");

    // 6: reset mid-clear at cnt=7, clear restarts from 0
    for (int i = 0; i < 7; i++) step();
    do_reset("t6");
    ready_low = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!p0_ready && !p1_ready) ready_low++;
      step();
    end
    chk("t6_ready_low_cycles", ready_low, 16);
    drive0(1'b0, 4'd3, '0, 2'b00);
    drive1(1'b0, 4'd5, '0, 2'b00);
    step();
    idle();
    chk("t6_cleared3", p0_rdata, 16'h0000);
    chk("t6_cleared5", p1_rdata, 16'h0000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
